// File: rtl/dmem_pkg.sv
// Shared types for the data-RAM arbiter: access sizes, arbitration states
// and the per-requester access bundle.
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } dmem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        OWN_M0 = 2'b01,
        OWN_M1 = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        lock;
    } dmem_req_t;

endpackage

// File: rtl/dmem_access_check.sv
// Combinational legality screen for one RAM access: size encoding,
// natural alignment and word-index range.
module dmem_access_check
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    output logic        illegal
);

    localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

    logic align_bad_s;
    logic range_bad_s;

    // Alignment by access size; the unused 2'b11 encoding is always rejected
    always_comb begin
        align_bad_s = 1'b1;
        case (size)
            SZ_BYTE: align_bad_s = 1'b0;
            SZ_HALF: align_bad_s = addr[0];
            SZ_WORD: align_bad_s = (addr[1:0] != 2'b00);
            default: align_bad_s = 1'b1;
        endcase
    end

    assign range_bad_s = ({2'b00, addr[31:2]} >= MEM_WORDS_W);
    assign illegal     = align_bad_s | range_bad_s;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter with bounded lock in front of the
// single-port data RAM; one-cycle registered response per requester.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 256,
    parameter int unsigned LOCK_MAX  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [1:0]  m0_size,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [1:0]  m1_size,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_rdata
);

    localparam logic [7:0] LOCK_MAX_W = 8'(LOCK_MAX);

    arb_state_e  state_r, state_nxt_s;
    logic        last_grant_r, last_grant_nxt_s;
    logic [7:0]  lock_cnt_r, lock_cnt_nxt_s;

    dmem_req_t   req0_s, req1_s, win_req_s;
    logic        hold_s, any_s, win1_s, other_req_s, grant_ok_s;
    logic        illegal_s;
    logic [31:0] rsp_data_s;

    assign req0_s = {m0_we, m0_addr, m0_wdata, m0_size, m0_lock};
    assign req1_s = {m1_we, m1_addr, m1_wdata, m1_size, m1_lock};

    // Winner selection and lock bookkeeping; a locked owner releases in the
    // same cycle its release condition appears, so the waiter wins at once
    always_comb begin
        hold_s           = 1'b0;
        any_s            = 1'b0;
        win1_s           = 1'b0;
        state_nxt_s      = IDLE;
        lock_cnt_nxt_s   = 8'd0;
        last_grant_nxt_s = last_grant_r;

        case (state_r)
            OWN_M0:  hold_s = m0_req & m0_lock & ~(m1_req & (lock_cnt_r >= LOCK_MAX_W));
            OWN_M1:  hold_s = m1_req & m1_lock & ~(m0_req & (lock_cnt_r >= LOCK_MAX_W));
            default: hold_s = 1'b0;
        endcase

        if (hold_s) begin
            any_s  = 1'b1;
            win1_s = (state_r == OWN_M1);
        end else if (m0_req && m1_req) begin
            any_s  = 1'b1;
            win1_s = ~last_grant_r;
        end else if (m0_req) begin
            any_s  = 1'b1;
            win1_s = 1'b0;
        end else if (m1_req) begin
            any_s  = 1'b1;
            win1_s = 1'b1;
        end else begin
            any_s  = 1'b0;
            win1_s = 1'b0;
        end

        other_req_s = win1_s ? m0_req : m1_req;

        if (!any_s) begin
            state_nxt_s    = IDLE;
            lock_cnt_nxt_s = 8'd0;
        end else if (hold_s) begin
            state_nxt_s    = state_r;
            lock_cnt_nxt_s = lock_cnt_r + {7'd0, other_req_s};
        end else if ((win1_s ? m1_lock : m0_lock)) begin
            state_nxt_s    = win1_s ? OWN_M1 : OWN_M0;
            lock_cnt_nxt_s = 8'd1;
        end else begin
            state_nxt_s    = IDLE;
            lock_cnt_nxt_s = 8'd0;
        end

        if (any_s) begin
            last_grant_nxt_s = win1_s;
        end else begin
            last_grant_nxt_s = last_grant_r;
        end
    end

    assign grant_ok_s = any_s & reset_n;
    assign m0_gnt     = grant_ok_s & ~win1_s;
    assign m1_gnt     = grant_ok_s &  win1_s;
    assign win_req_s  = win1_s ? req1_s : req0_s;

    dmem_access_check #(.MEM_WORDS(MEM_WORDS)) u_check (
        .size    (win_req_s.size),
        .addr    (win_req_s.addr),
        .illegal (illegal_s)
    );

    // RAM port follows the winner; illegal accesses never write
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = 32'd0;
        ram_wdata = 32'd0;
        ram_size  = 2'b00;
        if (grant_ok_s) begin
            ram_we    = win_req_s.we & ~illegal_s;
            ram_addr  = win_req_s.addr;
            ram_wdata = win_req_s.wdata;
            ram_size  = win_req_s.size;
        end else begin
            ram_we    = 1'b0;
        end
    end

    assign rsp_data_s = (!illegal_s && !win_req_s.we) ? ram_rdata : 32'd0;

    // Arbitration state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            lock_cnt_r   <= 8'd0;
        end else begin
            state_r      <= state_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            lock_cnt_r   <= lock_cnt_nxt_s;
        end
    end

    // Registered responses; a non-winner keeps its last read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= 32'd0;
            m0_err    <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= 32'd0;
            m1_err    <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt;
            m1_rvalid <= m1_gnt;
            if (m0_gnt) begin
                m0_rdata <= rsp_data_s;
                m0_err   <= illegal_s;
            end else begin
                m0_err   <= 1'b0;
            end
            if (m1_gnt) begin
                m1_rdata <= rsp_data_s;
                m1_err   <= illegal_s;
            end else begin
                m1_err   <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data RAM (byte/half/word sized writes, 256 x 32-bit words).
- Requester 0 is the CPU load/store path; requester 1 is the program-loader/debug port.
- Arbitrates per cycle with round-robin fairness and supports a bounded lock for multi-beat transfers.
- Screens illegal accesses and returns registered read data with a one-cycle response.

Parameters:
- MEM_WORDS, 256, number of 32-bit words in the RAM. An access is out of range when addr[31:2] >= MEM_WORDS.
- LOCK_MAX, 8, maximum consecutive cycles a locked owner keeps the RAM while the other requester waits. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- m0_req  in  1  requester 0 access request
- m0_lock  in  1  requester 0 asks to keep ownership after this access
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- m0_gnt  out  1  access accepted this cycle (combinational)
- m0_rvalid  out  1  response valid, one cycle after grant
- m0_rdata  out  32  registered read data
- m0_err  out  1  error flag, qualified by m0_rvalid
- m1_req, m1_lock, m1_we, m1_addr, m1_wdata, m1_size, m1_gnt, m1_rvalid, m1_rdata, m1_err: same as m0_*
- ram_we  out  1  to RAM we
- ram_addr  out  32  to RAM addr
- ram_wdata  out  32  to RAM wData
- ram_size  out  2  to RAM size
- ram_rdata  in  32  from RAM rData (combinational read)

Behaviour:
- Reset: all registered outputs are 0, FSM = IDLE, last_grant = 1 (so m0 wins the first tie), lock_cnt = 0. Reset may assert mid-transfer; a pending rvalid is dropped.
- Grant is combinational. The winner's gnt = 1 in the cycle it is selected. The RAM port mux follows the winner. With no winner, ram_we = 0 and the address/data outputs are 0.
- Request handshake: a requester holds req and its fields stable until it sees gnt.
- IDLE state:
  - Only one requester asserting req: it wins.
  - Both asserting req: the requester that is not last_grant wins.
  - last_grant updates at every grant.
- Lock:
  - A grant with lock = 1 moves the FSM to OWN_m (for the winning requester m) and loads lock_cnt = 1.
  - In OWN_m, m wins whenever m_req = 1.
  - lock_cnt increments on each cycle the other requester is waiting.
  - The FSM returns to IDLE when m drops req or lock, or when lock_cnt reaches LOCK_MAX while the other requester is waiting. The release takes effect in the same cycle the condition is seen, so the other requester is granted that cycle.
  - If m drops req in OWN_m, no grant goes to m, and the other requester may win in that same cycle.
- Legality check, applied to the winner:
  - Illegal when size = 11.
  - Illegal when size = 01 and addr[0] = 1.
  - Illegal when size = 10 and addr[1:0] != 00.
  - Illegal when addr[31:2] >= MEM_WORDS.
  - An illegal access is still granted, but ram_we is forced to 0.
- Response, in cycle N+1 after a grant at edge N:
  - The winner's rvalid = 1.
  - rdata = ram_rdata sampled at edge N for a legal read; 0 for writes and for illegal accesses.
  - err = 1 iff the access was illegal.
  - The non-winner's rvalid = 0 and its rdata holds its previous value.
- Write timing: the RAM commits the write at the grant edge, so a read granted on the next cycle returns the new data.
- Back-to-back grants, including alternating requesters, are allowed every cycle. Throughput is 1 access per cycle.

Decomposition:
- Shared package dmem_pkg holds:
  - size enum: SZ_BYTE = 00, SZ_HALF = 01, SZ_WORD = 10.
  - FSM enum: IDLE, OWN_M0, OWN_M1.
  - Struct dmem_req_t {we, addr, wdata, size, lock}.
- One sub-module: dmem_access_check. It is combinational; its inputs are size, addr and MEM_WORDS, and its output is illegal.

Test Plan:
- m0 writes word 0xDEADBEEF to 0x10; next cycle m0 reads 0x10 -> m0_gnt same cycle each time, m0_rvalid one cycle later, m0_rdata = 0xDEADBEEF, m0_err = 0.
- m0 and m1 both request every cycle from reset, no lock -> grants alternate m0, m1, m0, m1 for 8 cycles, never both in one cycle.
- m1 with lock = 1 and m0 waiting, LOCK_MAX = 8 -> m1 granted 8 consecutive cycles, then m0 granted in the 9th cycle, FSM in IDLE.
- m0 half write to 0x21, and m0 word read at 0x400 with MEM_WORDS = 256 -> gnt = 1 and ram_we = 0 for both; next cycle rvalid = 1, err = 1, rdata = 0; RAM contents unchanged.
- Byte write 0xAA to 0x13 over a word 0x11223344 at 0x10, then word read 0x10 -> rdata = 0xAA223344.
- reset_n driven low while m0 is in OWN_M0 with a read response pending -> all outputs 0 immediately; after release, a tie grants m0 first.
